// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter for a slotted SDRAM controller with one access in flight.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed p0 priority.
module sdram_port_arbiter #(
  parameter int unsigned SLOT_CYCLES = 8,
  parameter int unsigned AW          = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [15:0]   p0_wdata,
  input  logic [15:0]   p1_wdata,
  input  logic [1:0]    p0_be,
  input  logic [1:0]    p1_be,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic [15:0]   p0_rdata,
  output logic [15:0]   p1_rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout,
  output logic          mem_as,
  output logic [1:0]    mem_ds,
  output logic          mem_rw
);

  typedef enum logic [1:0] {
    S_IDLE, S_STROBE, S_WAIT, S_DONE
  } state_e;

  localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic          rw_q, rw_d;
  logic          as_q, as_d;
  logic [1:0]    ds_q, ds_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [15:0]   rd0_q, rd0_d;
  logic [15:0]   rd1_q, rd1_d;
  logic          busy_q, busy_d;
  logic          grant1;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // last_q=1 means p1 was granted last, so p0 wins a tie
  assign grant1 = p1_req & (~p0_req | ~last_q);
`else
  assign grant1 = p1_req & ~p0_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rw_d    = rw_q;
    as_d    = 1'b0;
    ds_d    = 2'b00;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (p0_req | p1_req) begin
          state_d = S_STROBE;
          sel_d   = grant1;
          addr_d  = grant1 ? p1_addr : p0_addr;
          din_d   = grant1 ? p1_wdata : p0_wdata;
          rw_d    = ~(grant1 ? p1_we : p0_we);
          as_d    = 1'b1;
          ds_d    = grant1 ? p1_be : p0_be;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          last_d  = grant1;
`endif
        end
      end
      S_STROBE: begin
        state_d = S_WAIT;
        cnt_d   = SLOT_LAST;
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          if (rw_q) begin
            if (sel_q) rd1_d = mem_dout;
            else       rd0_d = mem_dout;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= 16'd0;
      rw_q    <= 1'b0;
      as_q    <= 1'b0;
      ds_q    <= 2'b00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= 16'd0;
      rd1_q   <= 16'd0;
      busy_q  <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rw_q    <= rw_d;
      as_q    <= as_d;
      ds_q    <= ds_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      busy_q  <= busy_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign p0_ack   = ack0_q;
  assign p1_ack   = ack1_q;
  assign p0_rdata = rd0_q;
  assign p1_rdata = rd1_q;
  assign busy     = busy_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_as   = as_q;
  assign mem_ds   = ds_q;
  assign mem_rw   = rw_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a 16-word byte-lane memory model.
// Contention expectations follow SDRAM_ARB_ROUND_ROBIN_EN.
module tb_sdram_port_arbiter;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic          p0_we = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [15:0]   p0_wdata = '0, p1_wdata = '0;
  logic [1:0]    p0_be = '0, p1_be = '0;
  logic          p0_ack, p1_ack;
  logic [15:0]   p0_rdata, p1_rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din, mem_dout;
  logic          mem_as, mem_rw;
  logic [1:0]    mem_ds;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.SLOT_CYCLES(8), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p1_req(p1_req),
    .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_be(p0_be), .p1_be(p1_be),
    .p0_ack(p0_ack), .p1_ack(p1_ack),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_as(mem_as), .mem_ds(mem_ds), .mem_rw(mem_rw)
  );

  logic [15:0] mem [16];
  assign mem_dout = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) mem[k] <= 16'hA000 + 16'(k);
    end else if (mem_as && !mem_rw) begin
      if (mem_ds[0]) mem[mem_addr[3:0]][7:0]  <= mem_din[7:0];
      if (mem_ds[1]) mem[mem_addr[3:0]][15:8] <= mem_din[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         lat, as_cnt, other_ack, ds_bad;
  logic [1:0] ds_seen;
  logic       rw_seen, ack_after;

  task automatic access(input bit port, input bit we,
                        input logic [AW-1:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, input int drop_at);
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_be = be; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_be = be; p0_req = 1'b1;
    end
    lat = 0; as_cnt = 0; other_ack = 0; ds_bad = 0;
    ds_seen = 2'b00; rw_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_as) begin
        as_cnt++; ds_seen = mem_ds; rw_seen = mem_rw;
      end else if (mem_ds != 2'b00) ds_bad++;
      if (port ? p0_ack : p1_ack) other_ack++;
      if (i == drop_at) begin
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
      end
      if (port ? p1_ack : p0_ack) begin
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    ack_after = port ? p1_ack : p0_ack;
  endtask

  int p0_first, p1_first, n0, n1, both, rst_acks;
  bit drop1, drained;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_as", mem_as, 0);
    check("rst_ds", mem_ds, 0);
    check("rst_ack", {p0_ack, p1_ack}, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    check("rst_addr", mem_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 1'b1, 24'h000010, 16'h1234, 2'b11, 0);
    check("wr_lat", lat, 10);
    check("wr_as_cnt", as_cnt, 1);
    check("wr_ds", ds_seen, 2'b11);
    check("wr_rw", rw_seen, 0);
    check("wr_other_ack", other_ack, 0);
    check("wr_ds_idle", ds_bad, 0);
    check("wr_ack_1cyc", ack_after, 0);
    check("wr_addr_hold", mem_addr, 24'h000010);
    check("wr_din_hold", mem_din, 16'h1234);
    check("wr_busy_idle", busy, 0);

    access(1'b1, 1'b0, 24'h000010, 16'h0000, 2'b11, 0);
    check("p1rd_lat", lat, 10);
    check("p1rd_rw", rw_seen, 1);
    check("p1rd_other_ack", other_ack, 0);
    check("p1rd_rdata", p1_rdata, 16'h1234);
    check("p1rd_p0_keep", p0_rdata, 16'h0000);

    access(1'b0, 1'b0, 24'h000005, 16'h0000, 2'b11, 0);
    check("p0rd_rdata", p0_rdata, 16'hA005);
    check("p0rd_p1_keep", p1_rdata, 16'h1234);

    access(1'b0, 1'b1, 24'h000005, 16'hBEEF, 2'b10, 4);
    check("drop_lat", lat, 10);
    check("drop_as_cnt", as_cnt, 1);
    check("drop_ds", ds_seen, 2'b10);
    check("drop_rdata_keep", p0_rdata, 16'hA005);

    access(1'b0, 1'b0, 24'h000005, 16'h0000, 2'b11, 0);
    check("byte_rdata", p0_rdata, 16'hBE05);

    p0_we = 1'b0; p0_addr = 24'h000010; p0_be = 2'b11;
    p1_we = 1'b0; p1_addr = 24'h000005; p1_be = 2'b11;
    p0_req = 1'b1; p1_req = 1'b1;
    p0_first = 0; p1_first = 0; n0 = 0; n1 = 0; both = 0; drop1 = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk); #1;
      if (drop1) begin
        p1_req = 1'b0; drop1 = 1'b0;
      end
      if (p0_ack && p1_ack) both++;
      if (p0_ack) begin
        n0++;
        if (p0_first == 0) p0_first = i;
      end
      if (p1_ack) begin
        n1++;
        if (p1_first == 0) p1_first = i;
        drop1 = 1'b1;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        drained = 1'b1;
        break;
      end
    end
    check("ct_drained", drained, 1);
    check("ct_both_ack", both, 0);
    check("ct_p0_first", p0_first, 10);
    check("ct_p0_rdata", p0_rdata, 16'h1234);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    check("ct_p1_first", p1_first, 21);
    check("ct_n0", n0, 2);
    check("ct_n1", n1, 1);
    check("ct_p1_rdata", p1_rdata, 16'hBE05);
`else
    check("ct_p1_first", p1_first, 0);
    check("ct_n0", n0, 3);
    check("ct_n1", n1, 0);
    check("ct_p1_rdata", p1_rdata, 16'h1234);
`endif

    @(posedge clk); #1;
    p0_we = 1'b1; p0_addr = 24'h000003; p0_wdata = 16'h5555; p0_be = 2'b11;
    p0_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ar_busy_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ds", mem_ds, 0);
    check("ar_busy", busy, 0);
    check("ar_as", mem_as, 0);
    check("ar_p1_rdata", p1_rdata, 0);
    p0_req = 1'b0;
    rst_acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack) rst_acks++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack || busy) rst_acks++;
    end
    check("ar_no_ack", rst_acks, 0);
    access(1'b0, 1'b0, 24'h000010, 16'h0000, 2'b11, 0);
    check("ar_next_lat", lat, 10);
    check("ar_next_rdata", p0_rdata, 16'hA000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
